// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access engine with valid/ready bus, lane placement and load extension.
// Define LSU_MISALIGNED_SPLIT_EN to serve misaligned accesses (two beats across a word boundary) instead of erroring.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       mem_data,
    output logic              access_err,
    output logic              stall,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);
    typedef enum logic [2:0] {IDLE, BEAT1, WAIT1, BEAT2, WAIT2, DONE} state_t;
    state_t state_reg, state_next;

    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic [31:0]       rdata1_reg;
    logic [31:0]       mem_data_reg;

    // Request legality is decided from the live request fields in IDLE.
    logic req_illegal;
    logic req_err;
    assign req_illegal = req_write ? (req_funct3 > 3'b010)
                                   : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign req_err = req_illegal;
`else
    assign req_err = req_illegal
                   || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    logic [1:0]  k;
    logic [3:0]  size_mask;
    logic [7:0]  strobe8;
    logic        split;
    assign k = addr_reg[1:0];

    always_comb begin
        size_mask = 4'b1111;
        case (f3_reg[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes spilling past bit 3 belong to the second beat.
    assign strobe8 = {4'b0000, size_mask} << k;
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign split = |strobe8[7:4];
`else
    assign split = 1'b0;
`endif

    logic [31:0] wsized;
    logic [63:0] wshift;
    logic [31:0] wbeat1;
    always_comb begin
        wsized = wdata_reg;
        wbeat1 = wshift[31:0];
        case (f3_reg[1:0])
            2'b00:   wsized = {24'h0, wdata_reg[7:0]};
            2'b01:   wsized = {16'h0, wdata_reg[15:0]};
            default: wsized = wdata_reg;
        endcase
        if (f3_reg[1:0] == 2'b00)
            wbeat1 = {4{wdata_reg[7:0]}};
        else if ((f3_reg[1:0] == 2'b01) && !k[0])
            wbeat1 = {2{wdata_reg[15:0]}};
    end
    assign wshift = {32'h0, wsized} << {k, 3'b000};

    logic [63:0] rcomb;
    logic [31:0] rshift;
    logic [31:0] load_ext;
    logic        sext;
    assign rcomb  = split ? {bus_rdata, rdata1_reg} : {32'h0, bus_rdata};
    assign rshift = 32'(rcomb >> {k, 3'b000});
    assign sext   = ~f3_reg[2];

    always_comb begin
        load_ext = rshift;
        case (f3_reg[1:0])
            2'b00:   load_ext = {{24{sext & rshift[7]}}, rshift[7:0]};
            2'b01:   load_ext = {{16{sext & rshift[15]}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid)  state_next = req_err ? DONE : BEAT1;
            BEAT1:   if (bus_ready)  state_next = we_reg ? (split ? BEAT2 : DONE) : WAIT1;
            WAIT1:   if (bus_rvalid) state_next = split ? BEAT2 : DONE;
            BEAT2:   if (bus_ready)  state_next = we_reg ? DONE : WAIT2;
            WAIT2:   if (bus_rvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg       <= 1'b0;
            f3_reg       <= 3'b000;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
            rdata1_reg   <= 32'h0;
            mem_data_reg <= 32'h0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                we_reg    <= req_write;
                f3_reg    <= req_funct3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                err_reg   <= req_err;
                if (req_err) mem_data_reg <= 32'h0;
            end
            if (state_reg == WAIT1 && bus_rvalid) begin
                if (split) rdata1_reg   <= bus_rdata;
                else       mem_data_reg <= load_ext;
            end
            if (state_reg == WAIT2 && bus_rvalid)
                mem_data_reg <= load_ext;
        end
    end

    // Bus outputs derive from state so they fall with the asynchronous reset and hold while waiting.
    logic [ADDR_W-1:0] base_addr;
    assign base_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign bus_valid  = (state_reg == BEAT1) || (state_reg == BEAT2);
    assign bus_we     = bus_valid & we_reg;
    assign bus_addr   = (state_reg == BEAT1) ? base_addr
                      : (state_reg == BEAT2) ? base_addr + ADDR_W'(4) : '0;
    assign bus_wstrb  = (state_reg == BEAT1) ? strobe8[3:0]
                      : (state_reg == BEAT2) ? strobe8[7:4] : 4'b0000;
    assign bus_wdata  = (state_reg == BEAT1) ? wbeat1
                      : (state_reg == BEAT2) ? wshift[63:32] : 32'h0;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign access_err = (state_reg == DONE) & err_reg;
    assign mem_data   = mem_data_reg;
    assign stall      = req_valid & ~resp_valid;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench with a responding bus model and a response scoreboard.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] mem_data;
    logic        access_err;
    logic        stall;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .mem_data(mem_data), .access_err(access_err), .stall(stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd1, rd2;
        int          rdy_dly, rv_dly, spur;
        logic        err;
        int          beats;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
        logic [31:0] a2;
        logic [3:0]  s2;
        logic [31:0] d2;
        logic [31:0] mem;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input string n, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input int rdy, input int rv, input int spur,
                                input logic err, input int beats,
                                input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                                input logic [31:0] a2, input logic [3:0] s2, input logic [31:0] d2,
                                input logic [31:0] mem, input int lat);
        vec_t v;
        v.name = n; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rd1 = rd1; v.rd2 = rd2; v.rdy_dly = rdy; v.rv_dly = rv; v.spur = spur;
        v.err = err; v.beats = beats; v.a1 = a1; v.s1 = s1; v.d1 = d1;
        v.a2 = a2; v.s2 = s2; v.d2 = d2; v.mem = mem; v.lat = lat;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   c, wait_cnt, beats_seen, rv_at, rv_beat;
        logic done;
        vec_t e;
        c = 0; wait_cnt = 0; beats_seen = 0; rv_at = -1; rv_beat = 0; done = 1'b0;
        @(negedge clk);
        check1({v.name, " req_ready_before"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        exp_q.push_back(v);
        while (!done) begin
            @(negedge clk);
            c++;
            bus_ready = 1'b0;
            bus_rvalid = 1'b0;
            check1({v.name, " stall"}, stall, c < v.lat);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checkint({v.name, " scoreboard_depth"}, 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    checkint({e.name, " latency"}, c, e.lat);
                    check1({e.name, " access_err"}, access_err, e.err);
                    checkint({e.name, " beats"}, beats_seen, e.beats);
                    if (!e.wr || e.err) check32({e.name, " mem_data"}, mem_data, e.mem);
                    $display("txn %s: latency=%0d beats=%0d mem_data=%h access_err=%b",
                             e.name, c, beats_seen, mem_data, access_err);
                end
                req_valid = 1'b0;
                done = 1'b1;
            end else if (bus_valid) begin
                check32({v.name, " bus_addr"}, bus_addr, (beats_seen == 0) ? v.a1 : v.a2);
                if (wait_cnt >= v.rdy_dly) begin
                    bus_ready = 1'b1;
                    check1({v.name, " bus_we"}, bus_we, v.wr);
                    if (v.wr) begin
                        check32({v.name, " bus_wstrb"}, {28'h0, bus_wstrb},
                                {28'h0, (beats_seen == 0) ? v.s1 : v.s2});
                        check32({v.name, " bus_wdata"}, bus_wdata, (beats_seen == 0) ? v.d1 : v.d2);
                    end
                    beats_seen++;
                    wait_cnt = 0;
                    if (!v.wr) begin
                        rv_at = c + v.rv_dly;
                        rv_beat = beats_seen;
                    end
                end else begin
                    wait_cnt++;
                end
            end
            if (c == rv_at) begin
                bus_rvalid = 1'b1;
                bus_rdata = (rv_beat == 2) ? v.rd2 : v.rd1;
            end else if (c == v.spur) begin
                bus_rvalid = 1'b1;
                bus_rdata = 32'hDEAD0000;
            end
            if (!done && c > 40) begin
                checkint({v.name, " response_timeout"}, c, v.lat);
                req_valid = 1'b0;
                bus_ready = 1'b0;
                bus_rvalid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                done = 1'b1;
            end
        end
        @(negedge clk);
        bus_rvalid = 1'b0;
        check1({v.name, " req_ready_after"}, req_ready, 1'b1);
        check1({v.name, " resp_single_pulse"}, resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_resp;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        vecs.push_back(mk("sb_203",      1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 1, -1, 0, 1,
                          32'h200, 4'b1000, 32'hA5A5A5A5, 0, 4'b0000, 0, 0, 2));
        vecs.push_back(mk("lb_102",      0, 3'b000, 32'h102, 0, 32'h12803456, 0, 0, 1, -1, 0, 1,
                          32'h100, 4'b0000, 0, 0, 4'b0000, 0, 32'hFFFFFF80, 3));
        vecs.push_back(mk("lbu_102",     0, 3'b100, 32'h102, 0, 32'h12803456, 0, 0, 1, -1, 0, 1,
                          32'h100, 4'b0000, 0, 0, 4'b0000, 0, 32'h00000080, 3));
        vecs.push_back(mk("lw_300_wait", 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 0, 3, 1, 2, 0, 1,
                          32'h300, 4'b0000, 0, 0, 4'b0000, 0, 32'hCAFEF00D, 6));
        vecs.push_back(mk("ld_f3_110",   0, 3'b110, 32'h040, 0, 0, 0, 0, 1, -1, 1, 0,
                          0, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 1));
`ifdef LSU_MISALIGNED_SPLIT_EN
        vecs.push_back(mk("lw_0fe",      0, 3'b010, 32'h0FE, 0, 32'hAABBCCDD, 32'h11223344, 0, 1, -1, 0, 2,
                          32'h0FC, 4'b0000, 0, 32'h100, 4'b0000, 0, 32'h3344AABB, 5));
`else
        vecs.push_back(mk("lw_0fe",      0, 3'b010, 32'h0FE, 0, 32'hAABBCCDD, 32'h11223344, 0, 1, -1, 1, 0,
                          0, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 1));
`endif
        vecs.push_back(mk("sh_102",      1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0, 1, -1, 0, 1,
                          32'h100, 4'b1100, 32'hBEEFBEEF, 0, 4'b0000, 0, 0, 2));
        vecs.push_back(mk("sw_400",      1, 3'b010, 32'h400, 32'hDEADBEEF, 0, 0, 0, 1, -1, 0, 1,
                          32'h400, 4'b1111, 32'hDEADBEEF, 0, 4'b0000, 0, 0, 2));
        vecs.push_back(mk("lh_106",      0, 3'b001, 32'h106, 0, 32'h80011234, 0, 0, 1, -1, 0, 1,
                          32'h104, 4'b0000, 0, 0, 4'b0000, 0, 32'hFFFF8001, 3));
        vecs.push_back(mk("lhu_106",     0, 3'b101, 32'h106, 0, 32'h80011234, 0, 0, 1, -1, 0, 1,
                          32'h104, 4'b0000, 0, 0, 4'b0000, 0, 32'h00008001, 3));
        vecs.push_back(mk("sw_f3_011",   1, 3'b011, 32'h010, 32'h12345678, 0, 0, 0, 1, -1, 1, 0,
                          0, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("lw_500_rv3",  0, 3'b010, 32'h500, 0, 32'h0BADF00D, 0, 1, 3, -1, 0, 1,
                          32'h500, 4'b0000, 0, 0, 4'b0000, 0, 32'h0BADF00D, 6));
`ifdef LSU_MISALIGNED_SPLIT_EN
        vecs.push_back(mk("sh_101",      1, 3'b001, 32'h101, 32'hFFFFABCD, 0, 0, 0, 1, -1, 0, 1,
                          32'h100, 4'b0110, 32'h00ABCD00, 0, 4'b0000, 0, 0, 2));
        vecs.push_back(mk("sw_0fd",      1, 3'b010, 32'h0FD, 32'h11223344, 0, 0, 0, 1, -1, 0, 2,
                          32'h0FC, 4'b1110, 32'h22334400, 32'h100, 4'b0001, 32'h00000011, 0, 3));
`else
        vecs.push_back(mk("sh_101",      1, 3'b001, 32'h101, 32'hFFFFABCD, 0, 0, 0, 1, -1, 1, 0,
                          0, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("sw_0fd",      1, 3'b010, 32'h0FD, 32'h11223344, 0, 0, 0, 1, -1, 1, 0,
                          0, 4'b0000, 0, 0, 4'b0000, 0, 32'h0, 1));
`endif
        vecs.push_back(mk("lb_0ff",      0, 3'b000, 32'h0FF, 0, 32'h7F000000, 0, 0, 1, -1, 0, 1,
                          32'h0FC, 4'b0000, 0, 0, 4'b0000, 0, 32'h0000007F, 3));

        // Reset values.
        #12;
        check1("rst req_ready", req_ready, 1'b1);
        check1("rst resp_valid", resp_valid, 1'b0);
        check32("rst mem_data", mem_data, 32'h0);
        check1("rst access_err", access_err, 1'b0);
        check1("rst bus_valid", bus_valid, 1'b0);
        check1("rst bus_we", bus_we, 1'b0);
        check32("rst bus_addr", bus_addr, 32'h0);
        check32("rst bus_wdata", bus_wdata, 32'h0);
        check32("rst bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        check1("rst stall_low", stall, 1'b0);
        req_valid = 1'b1;
        #1;
        check1("rst stall_follows", stall, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted during WAIT1; a late rvalid must not produce a response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        check1("rstw beat1_valid", bus_valid, 1'b1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        check1("rstw bus_valid", bus_valid, 1'b0);
        check1("rstw req_ready", req_ready, 1'b1);
        check1("rstw resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seen_resp = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus_rvalid = (i == 2);
            bus_rdata = 32'h5555AAAA;
            if (resp_valid) seen_resp = 1'b1;
        end
        bus_rvalid = 1'b0;
        check1("rstw no_resp", seen_resp, 1'b0);
        check1("rstw idle", req_ready, 1'b1);
        check1("rstw bus_idle", bus_valid, 1'b0);
        $display("txn reset_in_wait1: resp_seen=%b", seen_resp);

        // Reset mid-cycle during BEAT1 drops bus_valid without waiting for a clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h180;
        @(negedge clk);
        check1("rstb beat1_valid", bus_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check1("rstb async_drop", bus_valid, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check1("rstb idle", req_ready, 1'b1);
        $display("txn reset_in_beat1: bus_valid=%b", bus_valid);

        foreach (vecs[i]) run_txn(vecs[i]);
        checkint("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access engine between the execute stage and the data bus. Takes a load/store request (address from the ALU, store data from rs2, funct3 width code), runs a valid/ready transaction on the memory bus, and returns aligned, sign/zero-extended load data as `mem_data`, which feeds the `MemoryData` input of the write-back result-select mux. It stalls the core for the duration of each access.

## Interface

- Clock/reset: one clock; reset is asynchronous and active-high (`clk`, `reset`).
- `ADDR_W`, default 32, address width; data is fixed at 32 bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  core request; held, with all other `req_*` stable, until the `resp_valid` cycle.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse: access complete.
- `mem_data`  out  32  extended load data; valid and held from `resp_valid` until the next response.
- `access_err`  out  1  pulses with `resp_valid` on an illegal funct3 or an unsupported misaligned access.
- `stall`  out  1  equals `req_valid & ~resp_valid` (combinational).
- `bus_valid`  out  1  bus request.
- `bus_ready`  in  1  bus accepts the request.
- `bus_we`  out  1  write enable.
- `bus_addr`  out  ADDR_W  word-aligned address; `[1:0]` is always 0.
- `bus_wdata`  out  32  lane-positioned store data.
- `bus_wstrb`  out  4  byte strobes.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.

## Operation

- Request acceptance: a request is accepted when `req_valid & req_ready`, and all fields are captured on that edge.
- States: IDLE, BEAT1, WAIT1, BEAT2, WAIT2, DONE.
  - IDLE → BEAT1 on acceptance. An illegal or unsupported access goes IDLE → DONE with `access_err` and makes no bus transaction.
  - BEATn holds `bus_valid` until `bus_ready`. A store then goes to DONE (or to BEAT2 if split). A load goes to WAITn.
  - WAITn waits for `bus_rvalid` and captures `bus_rdata`. It then goes to BEAT2 if split, otherwise to DONE.
  - DONE asserts `resp_valid` for one cycle, then returns to IDLE.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value above 010.
- Store lane placement, with k = `addr[1:0]`:
  - SB: byte replicated to all lanes, strobe `4'b0001<<k`.
  - SH: halfword duplicated, strobe `4'b0011<<k`.
  - SW: strobe 1111.
- Load extraction: take `rdata >> 8k`. LB/LH sign-extend; LBU/LHU zero-extend.
- `bus_rvalid` is ignored outside the WAIT states.
- `bus_valid` and `bus_addr` are stable while waiting for `bus_ready`.

## Timing

- Reset values:
  - State IDLE.
  - `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`: 0.
  - `resp_valid`, `mem_data`, `access_err`: 0.
  - `req_ready` = 1.
  - `stall` follows `req_valid`.
- Acceptance in cycle 0; `bus_valid` asserts in cycle 1.
- Store with `bus_ready`=1 in cycle 1: `resp_valid` in cycle 2.
- Load with `bus_ready`=1 in cycle 1 and `bus_rvalid` in cycle 2: `resp_valid` and `mem_data` in cycle 3.
- Error path: `resp_valid` and `access_err` in cycle 1.
- Every bus wait cycle adds one cycle of latency.
- A split access adds one full beat.
- Reset mid-access:
  - Immediate return to IDLE; `bus_valid` drops asynchronously.
  - A late `bus_rvalid` is discarded and produces no `resp_valid`.

## Configuration

- Macro: `LSU_MISALIGNED_SPLIT_EN`.
- Without the macro:
  - Any LH/LHU/SH with `addr[0]`=1, or any LW/SW with `addr[1:0]`≠0, takes the error path.
  - `mem_data` is 0 on the error path.
- With the macro:
  - A misaligned access contained in one word uses one beat.
  - An access crossing a word boundary uses two beats: `addr&~3`, then `(addr&~3)+4`.
  - Beat 1 strobe is `(4'b1111<<k)` masked to the access size. Beat 2 strobe is the remainder in the low lanes. Data is shifted to match.
  - Load result: `{rdata2,rdata1}>>8k`, truncated to the access size, then extended.
  - `access_err` is raised only for illegal funct3.

## Test plan

- Reset mid-WAIT1 for an LW at 0x100, with `bus_rvalid` asserted 2 cycles after reset release → state IDLE, `resp_valid` never pulses, `bus_valid`=0.
- SB at 0x203, wdata 0x000000A5, `bus_ready` tied 1 → one beat: addr 0x200, wstrb 1000, wdata 0xA5A5A5A5, `resp_valid` in cycle 2.
- LB at 0x102, rdata 0x12803456 → `mem_data` 0xFFFFFF80 in cycle 3. The same access as LBU → 0x00000080.
- LW at 0x300, `bus_ready` low for 3 cycles, `bus_rvalid` 2 cycles after acceptance → `bus_valid`/`bus_addr` stable throughout, `stall` high until `resp_valid`, `mem_data` equals rdata.
- LW at 0x0FE:
  - Without macro → no bus request, `access_err`=1 in cycle 1.
  - With macro, rdata 0xAABBCCDD at 0x0FC then 0x11223344 at 0x100 → `mem_data` 0x3344AABB.
- Load with funct3 110 → no bus activity, `access_err` and `resp_valid` in cycle 1, `req_ready` high again in cycle 2.
